rs_alu_issue: RTL and testbench

RS_ALU_ISSUE -- requirements
Module: rs_alu_issue

---
 rtl/rs_alu_issue.sv | 222 ++++++++++++++++++++++
 tb/tb_rs_alu_issue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_issue.sv
// rs_alu_issue -- reservation station in front of the integer ALU.
//
// Holds up to RS_SIZE dispatched instructions until both source operands are
// known, picks up operand values from the ALU and LSB result buses, and sends
// one ready instruction per cycle to the ALU through registered RS_* outputs.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   rdy                global stall, low = hold all state
//   roll               misprediction flush (clears every entry and RS_flag)
//   ISSUE_*            dispatch request from the decoder (op, PC, imm, ROB tag,
//                      operand j/k: pending flag, producer tag, value)
//   ALU_* / LSB_*      result buses (valid flag, ROB tag, value)
//   RS_full            combinational, high when every entry is busy
//   RS_flag, RS_*      registered issue to the ALU, RS_flag is a 1-cycle pulse
//
// Handshake: a dispatch is accepted at an edge where rdy & ISSUE_flag &
// !RS_full & !roll; the decoder must watch RS_full and hold its request.
// RS_flag has no back-pressure -- the ALU takes every pulse it sees.
//
// Build option: define RS_AGE_PRIORITY_EN to select the oldest ready entry
// (age matrix); otherwise the lowest-index ready entry is selected.

`ifndef ROB_INDEX_RANGE
`define ROB_INDEX_RANGE 3:0
`endif

module rs_alu_issue #(
   parameter int RS_SIZE  = 16,
   parameter int RS_IDX_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   roll,
   input  logic                   ISSUE_flag,
   input  logic [5:0]             ISSUE_op,
   input  logic [31:0]            ISSUE_PC,
   input  logic [31:0]            ISSUE_imm,
   input  logic [`ROB_INDEX_RANGE] ISSUE_idx,
   input  logic                   ISSUE_Qj_flag,
   input  logic [`ROB_INDEX_RANGE] ISSUE_Qj,
   input  logic [31:0]            ISSUE_Vj,
   input  logic                   ISSUE_Qk_flag,
   input  logic [`ROB_INDEX_RANGE] ISSUE_Qk,
   input  logic [31:0]            ISSUE_Vk,
   input  logic                   ALU_flag,
   input  logic [`ROB_INDEX_RANGE] ALU_ROB_idx,
   input  logic [31:0]            ALU_val,
   input  logic                   LSB_flag,
   input  logic [`ROB_INDEX_RANGE] LSB_ROB_idx,
   input  logic [31:0]            LSB_val,
   output logic                   RS_full,
   output logic                   RS_flag,
   output logic [5:0]             RS_op,
   output logic [31:0]            RS_Vj,
   output logic [31:0]            RS_Vk,
   output logic [`ROB_INDEX_RANGE] RS_idx,
   output logic [31:0]            RS_imm,
   output logic [31:0]            RS_PC
);

   // control state (reset)
   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] qj_flag;
   logic [RS_SIZE-1:0] qk_flag;

   // payload (no reset, only meaningful while busy)
   logic [5:0]             op_q   [RS_SIZE];
   logic [31:0]            pc_q   [RS_SIZE];
   logic [31:0]            imm_q  [RS_SIZE];
   logic [`ROB_INDEX_RANGE] dest_q [RS_SIZE];
   logic [`ROB_INDEX_RANGE] qj_q   [RS_SIZE];
   logic [`ROB_INDEX_RANGE] qk_q   [RS_SIZE];
   logic [31:0]            vj_q   [RS_SIZE];
   logic [31:0]            vk_q   [RS_SIZE];

`ifdef RS_AGE_PRIORITY_EN
   // age[a][b] = 1 means entry a was allocated before entry b
   logic [RS_SIZE-1:0] age [RS_SIZE];
`endif

   logic [RS_SIZE-1:0] ready;
   logic [RS_SIZE-1:0] cand;
   logic [RS_SIZE-1:0] j_alu, j_lsb, k_alu, k_lsb;
   logic                sel_found;
   logic [RS_IDX_W-1:0] sel_idx;
   logic [RS_IDX_W-1:0] free_idx;
   logic                alloc;
   logic                iss_j_alu, iss_j_lsb, iss_k_alu, iss_k_lsb;
   logic [31:0]         iss_vj, iss_vk;
   logic                iss_qj_pend, iss_qk_pend;

   assign RS_full = &busy;
   assign alloc   = ISSUE_flag & ~RS_full;

   // Readiness uses register state only, so a wakeup seen this cycle makes
   // the entry selectable on the following cycle.
   always_comb begin
      ready = busy & ~qj_flag & ~qk_flag;
      for (int i = 0; i < RS_SIZE; i++) begin
         j_alu[i] = busy[i] & qj_flag[i] & ALU_flag & (qj_q[i] == ALU_ROB_idx);
         j_lsb[i] = busy[i] & qj_flag[i] & LSB_flag & (qj_q[i] == LSB_ROB_idx);
         k_alu[i] = busy[i] & qk_flag[i] & ALU_flag & (qk_q[i] == ALU_ROB_idx);
         k_lsb[i] = busy[i] & qk_flag[i] & LSB_flag & (qk_q[i] == LSB_ROB_idx);
      end
   end

   // Selection candidates: every ready entry, or with ageing only ready
   // entries that no other ready entry is older than.
   always_comb begin
      cand = ready;
`ifdef RS_AGE_PRIORITY_EN
      for (int i = 0; i < RS_SIZE; i++) begin
         for (int j = 0; j < RS_SIZE; j++) begin
            if (ready[j] && age[j][i]) cand[i] = 1'b0;
         end
      end
`endif
   end

   // Lowest-index candidate and lowest-index free slot (descending scan,
   // last hit wins).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      free_idx  = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_found = 1'b1;
            sel_idx   = RS_IDX_W'(i);
         end
         if (!busy[i]) free_idx = RS_IDX_W'(i);
      end
   end

   // Operand capture at allocation: a result broadcast in the same cycle is
   // taken directly, ALU having priority over LSB on equal tags.
   always_comb begin
      iss_j_alu   = ISSUE_Qj_flag & ALU_flag & (ISSUE_Qj == ALU_ROB_idx);
      iss_j_lsb   = ISSUE_Qj_flag & LSB_flag & (ISSUE_Qj == LSB_ROB_idx);
      iss_k_alu   = ISSUE_Qk_flag & ALU_flag & (ISSUE_Qk == ALU_ROB_idx);
      iss_k_lsb   = ISSUE_Qk_flag & LSB_flag & (ISSUE_Qk == LSB_ROB_idx);
      iss_vj      = iss_j_alu ? ALU_val : (iss_j_lsb ? LSB_val : ISSUE_Vj);
      iss_vk      = iss_k_alu ? ALU_val : (iss_k_lsb ? LSB_val : ISSUE_Vk);
      iss_qj_pend = ISSUE_Qj_flag & ~iss_j_alu & ~iss_j_lsb;
      iss_qk_pend = ISSUE_Qk_flag & ~iss_k_alu & ~iss_k_lsb;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy    <= '0;
         qj_flag <= '0;
         qk_flag <= '0;
         RS_flag <= 1'b0;
         RS_op   <= '0;
         RS_Vj   <= '0;
         RS_Vk   <= '0;
         RS_idx  <= '0;
         RS_imm  <= '0;
         RS_PC   <= '0;
`ifdef RS_AGE_PRIORITY_EN
         for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
`endif
      end else if (roll) begin
         busy    <= '0;
         RS_flag <= 1'b0;
      end else if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (j_alu[i] || j_lsb[i]) qj_flag[i] <= 1'b0;
            if (k_alu[i] || k_lsb[i]) qk_flag[i] <= 1'b0;
         end
         if (sel_found) begin
            busy[sel_idx] <= 1'b0;
            RS_flag       <= 1'b1;
            RS_op         <= op_q[sel_idx];
            RS_Vj         <= vj_q[sel_idx];
            RS_Vk         <= vk_q[sel_idx];
            RS_idx        <= dest_q[sel_idx];
            RS_imm        <= imm_q[sel_idx];
            RS_PC         <= pc_q[sel_idx];
         end else begin
            RS_flag <= 1'b0;
         end
         // free_idx is never sel_idx: one is busy, the other is not
         if (alloc) begin
            busy[free_idx]    <= 1'b1;
            qj_flag[free_idx] <= iss_qj_pend;
            qk_flag[free_idx] <= iss_qk_pend;
`ifdef RS_AGE_PRIORITY_EN
            // new entry is younger than everything currently busy
            for (int j = 0; j < RS_SIZE; j++) begin
               age[j][free_idx] <= busy[j];
               age[free_idx][j] <= 1'b0;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && !roll) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (j_alu[i])      vj_q[i] <= ALU_val;
            else if (j_lsb[i]) vj_q[i] <= LSB_val;
            if (k_alu[i])      vk_q[i] <= ALU_val;
            else if (k_lsb[i]) vk_q[i] <= LSB_val;
         end
         if (alloc) begin
            op_q[free_idx]   <= ISSUE_op;
            pc_q[free_idx]   <= ISSUE_PC;
            imm_q[free_idx]  <= ISSUE_imm;
            dest_q[free_idx] <= ISSUE_idx;
            qj_q[free_idx]   <= ISSUE_Qj;
            qk_q[free_idx]   <= ISSUE_Qk;
            vj_q[free_idx]   <= iss_vj;
            vk_q[free_idx]   <= iss_vk;
         end
      end
   end

endmodule

// File: tb/tb_rs_alu_issue.sv
// Directed testbench for rs_alu_issue: reset, ready issue, ALU/LSB wakeup,
// same-cycle capture, tag collision, stall, full/roll, async reset and
// selection order (expectation follows RS_AGE_PRIORITY_EN).

`ifndef ROB_INDEX_RANGE
`define ROB_INDEX_RANGE 3:0
`endif

module tb_rs_alu_issue;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   rdy;
   logic                   roll;
   logic                   ISSUE_flag;
   logic [5:0]             ISSUE_op;
   logic [31:0]            ISSUE_PC;
   logic [31:0]            ISSUE_imm;
   logic [`ROB_INDEX_RANGE] ISSUE_idx;
   logic                   ISSUE_Qj_flag;
   logic [`ROB_INDEX_RANGE] ISSUE_Qj;
   logic [31:0]            ISSUE_Vj;
   logic                   ISSUE_Qk_flag;
   logic [`ROB_INDEX_RANGE] ISSUE_Qk;
   logic [31:0]            ISSUE_Vk;
   logic                   ALU_flag;
   logic [`ROB_INDEX_RANGE] ALU_ROB_idx;
   logic [31:0]            ALU_val;
   logic                   LSB_flag;
   logic [`ROB_INDEX_RANGE] LSB_ROB_idx;
   logic [31:0]            LSB_val;
   logic                   RS_full;
   logic                   RS_flag;
   logic [5:0]             RS_op;
   logic [31:0]            RS_Vj;
   logic [31:0]            RS_Vk;
   logic [`ROB_INDEX_RANGE] RS_idx;
   logic [31:0]            RS_imm;
   logic [31:0]            RS_PC;

   int n_checks = 0;
   int n_pass   = 0;

   rs_alu_issue dut (
      .clk(clk), .rst(rst), .rdy(rdy), .roll(roll),
      .ISSUE_flag(ISSUE_flag), .ISSUE_op(ISSUE_op), .ISSUE_PC(ISSUE_PC),
      .ISSUE_imm(ISSUE_imm), .ISSUE_idx(ISSUE_idx),
      .ISSUE_Qj_flag(ISSUE_Qj_flag), .ISSUE_Qj(ISSUE_Qj), .ISSUE_Vj(ISSUE_Vj),
      .ISSUE_Qk_flag(ISSUE_Qk_flag), .ISSUE_Qk(ISSUE_Qk), .ISSUE_Vk(ISSUE_Vk),
      .ALU_flag(ALU_flag), .ALU_ROB_idx(ALU_ROB_idx), .ALU_val(ALU_val),
      .LSB_flag(LSB_flag), .LSB_ROB_idx(LSB_ROB_idx), .LSB_val(LSB_val),
      .RS_full(RS_full), .RS_flag(RS_flag), .RS_op(RS_op), .RS_Vj(RS_Vj),
      .RS_Vk(RS_Vk), .RS_idx(RS_idx), .RS_imm(RS_imm), .RS_PC(RS_PC)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // advance one rising edge, leave inputs/outputs 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [3:0] idx,
                        input logic qjf, input logic [3:0] qj, input logic [31:0] vj,
                        input logic qkf, input logic [3:0] qk, input logic [31:0] vk);
      ISSUE_flag    = 1'b1;
      ISSUE_op      = op;
      ISSUE_PC      = 32'h1000 + {28'd0, idx};
      ISSUE_imm     = 32'h20 + {28'd0, idx};
      ISSUE_idx     = idx;
      ISSUE_Qj_flag = qjf;
      ISSUE_Qj      = qj;
      ISSUE_Vj      = vj;
      ISSUE_Qk_flag = qkf;
      ISSUE_Qk      = qk;
      ISSUE_Vk      = vk;
   endtask

   task automatic no_issue();
      ISSUE_flag = 1'b0;
   endtask

   task automatic alu_bcast(input logic f, input logic [3:0] tag, input logic [31:0] val);
      ALU_flag = f; ALU_ROB_idx = tag; ALU_val = val;
   endtask

   task automatic lsb_bcast(input logic f, input logic [3:0] tag, input logic [31:0] val);
      LSB_flag = f; LSB_ROB_idx = tag; LSB_val = val;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; roll = 1'b0;
      ISSUE_flag = 0; ISSUE_op = 0; ISSUE_PC = 0; ISSUE_imm = 0; ISSUE_idx = 0;
      ISSUE_Qj_flag = 0; ISSUE_Qj = 0; ISSUE_Vj = 0;
      ISSUE_Qk_flag = 0; ISSUE_Qk = 0; ISSUE_Vk = 0;
      alu_bcast(0, 0, 0);
      lsb_bcast(0, 0, 0);

      // reset state
      #2 rst = 1'b0;
      #1;
      check("rst_flag", {31'd0, RS_flag}, 32'd0);
      check("rst_full", {31'd0, RS_full}, 32'd0);
      check("rst_op", {26'd0, RS_op}, 32'd0);
      check("rst_vj", RS_Vj, 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      check("idle_flag", {31'd0, RS_flag}, 32'd0);

      // both operands ready: RS_flag on 2nd edge, single pulse
      issue(6'h01, 4'd3, 0, 0, 32'd5, 0, 0, 32'd7);
      tick();
      no_issue();
      check("add_edge1_flag", {31'd0, RS_flag}, 32'd0);
      tick();
      check("add_flag", {31'd0, RS_flag}, 32'd1);
      check("add_vj", RS_Vj, 32'd5);
      check("add_vk", RS_Vk, 32'd7);
      check("add_idx", {28'd0, RS_idx}, 32'd3);
      check("add_op", {26'd0, RS_op}, 32'h01);
      check("add_pc", RS_PC, 32'h1003);
      check("add_imm", RS_imm, 32'h23);
      tick();
      check("add_pulse_end", {31'd0, RS_flag}, 32'd0);
      check("add_hold_vj", RS_Vj, 32'd5);

      // Qj pending, woken by ALU broadcast
      issue(6'h02, 4'd4, 1, 4'd2, 32'hdead, 0, 0, 32'd11);
      tick();
      no_issue();
      tick(); tick();
      check("wait_j_flag", {31'd0, RS_flag}, 32'd0);
      alu_bcast(1, 4'd2, 32'h1234);
      tick();
      alu_bcast(0, 0, 0);
      check("wake_edge1_flag", {31'd0, RS_flag}, 32'd0);
      tick();
      check("wake_flag", {31'd0, RS_flag}, 32'd1);
      check("wake_vj", RS_Vj, 32'h1234);
      check("wake_vk", RS_Vk, 32'd11);
      check("wake_idx", {28'd0, RS_idx}, 32'd4);

      // Qk captured from LSB in the allocation cycle
      issue(6'h03, 4'd5, 0, 0, 32'd3, 1, 4'd6, 32'hbeef);
      lsb_bcast(1, 4'd6, 32'd9);
      tick();
      no_issue();
      lsb_bcast(0, 0, 0);
      tick();
      check("cap_flag", {31'd0, RS_flag}, 32'd1);
      check("cap_vk", RS_Vk, 32'd9);
      check("cap_idx", {28'd0, RS_idx}, 32'd5);

      // ALU and LSB on the same tag: ALU value wins
      issue(6'h04, 4'd6, 1, 4'd7, 32'd0, 0, 0, 32'd1);
      tick();
      no_issue();
      alu_bcast(1, 4'd7, 32'haa);
      lsb_bcast(1, 4'd7, 32'hbb);
      tick();
      alu_bcast(0, 0, 0);
      lsb_bcast(0, 0, 0);
      tick();
      check("coll_flag", {31'd0, RS_flag}, 32'd1);
      check("coll_vj", RS_Vj, 32'haa);
      tick();
      check("coll_pulse_end", {31'd0, RS_flag}, 32'd0);

      // stall: ready entry frozen, issue during stall ignored
      issue(6'h05, 4'd8, 0, 0, 32'd8, 0, 0, 32'd8);
      tick();
      rdy = 1'b0;
      issue(6'h06, 4'd9, 0, 0, 32'd9, 0, 0, 32'd9);
      tick(); tick();
      check("stall_flag", {31'd0, RS_flag}, 32'd0);
      check("stall_idx", {28'd0, RS_idx}, 32'd6);
      no_issue();
      rdy = 1'b1;
      tick();
      check("unstall_flag", {31'd0, RS_flag}, 32'd1);
      check("unstall_idx", {28'd0, RS_idx}, 32'd8);
      tick();
      check("stall_issue_dropped", {31'd0, RS_flag}, 32'd0);

      // fill every entry with pending operands
      for (int i = 0; i < 16; i++) begin
         issue(6'h07, 4'(i), 1, 4'd15, 32'd0, 0, 0, 32'd0);
         tick();
         if (i == 14) check("full_at_15", {31'd0, RS_full}, 32'd0);
      end
      check("full_at_16", {31'd0, RS_full}, 32'd1);
      issue(6'h08, 4'd12, 0, 0, 32'd1, 0, 0, 32'd2);
      tick();
      no_issue();
      tick(); tick();
      check("full_17th_ignored", {31'd0, RS_flag}, 32'd0);
      check("full_still", {31'd0, RS_full}, 32'd1);
      roll = 1'b1;
      alu_bcast(1, 4'd15, 32'h55);
      tick();
      roll = 1'b0;
      alu_bcast(0, 0, 0);
      check("roll_full", {31'd0, RS_full}, 32'd0);
      check("roll_flag", {31'd0, RS_flag}, 32'd0);
      alu_bcast(1, 4'd15, 32'h55);
      tick();
      alu_bcast(0, 0, 0);
      tick(); tick();
      check("roll_no_flag", {31'd0, RS_flag}, 32'd0);

      // async reset with busy entries and a live RS_flag
      for (int i = 1; i <= 3; i++) begin
         issue(6'h09, 4'(i), 1, 4'd14, 32'd0, 0, 0, 32'd0);
         tick();
      end
      issue(6'h2a, 4'd7, 0, 0, 32'h77, 0, 0, 32'h88);
      tick();
      no_issue();
      tick();
      check("pre_rst_flag", {31'd0, RS_flag}, 32'd1);
      rst = 1'b0;
      roll = 1'b1;
      #2;
      check("arst_flag", {31'd0, RS_flag}, 32'd0);
      check("arst_full", {31'd0, RS_full}, 32'd0);
      check("arst_op", {26'd0, RS_op}, 32'd0);
      check("arst_vj", RS_Vj, 32'd0);
      check("arst_vk", RS_Vk, 32'd0);
      check("arst_idx", {28'd0, RS_idx}, 32'd0);
      check("arst_imm", RS_imm, 32'd0);
      check("arst_pc", RS_PC, 32'd0);
      tick();
      rst = 1'b1;
      roll = 1'b0;
      alu_bcast(1, 4'd14, 32'h66);
      tick();
      alu_bcast(0, 0, 0);
      tick(); tick();
      check("post_rst_no_flag", {31'd0, RS_flag}, 32'd0);

      // selection order: entry 1 allocated before entry 0
      issue(6'h0a, 4'd10, 1, 4'd1, 32'd0, 0, 0, 32'd0);
      tick();
      issue(6'h0b, 4'd11, 1, 4'd2, 32'd0, 0, 0, 32'd0);
      tick();
      no_issue();
      alu_bcast(1, 4'd1, 32'h50);
      tick();
      alu_bcast(0, 0, 0);
      tick();
      check("age_a_flag", {31'd0, RS_flag}, 32'd1);
      check("age_a_idx", {28'd0, RS_idx}, 32'd10);
      issue(6'h0c, 4'd12, 1, 4'd3, 32'd0, 0, 0, 32'd0);
      tick();
      no_issue();
      alu_bcast(1, 4'd2, 32'h60);
      lsb_bcast(1, 4'd3, 32'h70);
      tick();
      alu_bcast(0, 0, 0);
      lsb_bcast(0, 0, 0);
      tick();
      check("age_first_flag", {31'd0, RS_flag}, 32'd1);
`ifdef RS_AGE_PRIORITY_EN
      check("age_first_idx", {28'd0, RS_idx}, 32'd11);
      check("age_first_vj", RS_Vj, 32'h60);
`else
      check("age_first_idx", {28'd0, RS_idx}, 32'd12);
      check("age_first_vj", RS_Vj, 32'h70);
`endif
      tick();
      check("age_second_flag", {31'd0, RS_flag}, 32'd1);
`ifdef RS_AGE_PRIORITY_EN
      check("age_second_idx", {28'd0, RS_idx}, 32'd12);
`else
      check("age_second_idx", {28'd0, RS_idx}, 32'd11);
`endif
      tick();
      check("age_done", {31'd0, RS_flag}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
